serial_frame_tx: RTL and testbench

- Parallel-to-serial frame transmitter: latches a DATA_WIDTH word through a valid/ready handshake and shifts it out on a single line as start bit, data bits LSB first, optional even-parity bit, stop bit.
- Transmitting end of the serial link for the mini-project datapath; the matching receiver samples `tx`.
- Parity bit is the XOR reduction of the data bits, built from the gate-level primitives used elsewhere in the design.

---
 rtl/serial_frame_tx.sv | 146 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial frame transmitter
// Frame: start(0), data LSB first, optional even parity, stop(1); tx is registered.
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           clk_cnt, clk_cnt_n;
  logic [BW-1:0]           bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_n;
  logic                    parity_q, parity_n;
  logic                    tx_q, tx_n;
  logic                    bit_done;
  logic                    parity_in;

  // XOR chain of gate primitives over the incoming word; each stage lives in its own block.
  genvar i;
  for (i = 0; i < DATA_WIDTH; i++) begin : g_par
    wire p;
    if (i == 0) begin : g_first
      assign p = data_in[0];
    end else begin : g_xor
      xor u_xor (p, g_par[i-1].p, data_in[i]);
    end
  end
  assign parity_in = g_par[DATA_WIDTH-1].p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      parity_q  <= parity_n;
      tx_q      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_reg;
    parity_n  = parity_q;
    tx_n      = 1'b1;
    bit_done  = (clk_cnt == CLK_LAST);

    case (state)
      IDLE: begin
        if (data_valid) begin
          state_n   = START;
          shift_n   = data_in;
          parity_n  = parity_in;
          clk_cnt_n = '0;
          bit_cnt_n = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          clk_cnt_n = '0;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shift_n   = shift_reg >> 1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_n   = STOP;
          clk_cnt_n = '0;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_n   = IDLE;
          clk_cnt_n = '0;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        clk_cnt_n = '0;
        bit_cnt_n = '0;
      end
    endcase

    // Line level is chosen from the upcoming state so tx lands in step with it.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = parity_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx
// Two instances: default parameters (A) and 8 bits / 1 clk per bit / no parity (B).
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       a_rst_n, b_rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready, a_tx, b_tx, a_busy, b_busy;
  logic       sel;
  logic       cur_tx, cur_busy, cur_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx u_a (
    .clk(clk), .rst_n(a_rst_n), .data_in(a_data), .data_valid(a_valid),
    .data_ready(a_ready), .tx(a_tx), .busy(a_busy)
  );

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .data_in(b_data), .data_valid(b_valid),
    .data_ready(b_ready), .tx(b_tx), .busy(b_busy)
  );

  assign cur_tx    = sel ? b_tx    : a_tx;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_ready = sel ? b_ready : a_ready;

  typedef struct {
    logic       dut;
    logic [7:0] data;
    logic [10:0] frame;  // bit nbits-1 is transmitted first
    int         nbits;
    int         cpb;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference frame built from the line rules: start 0, data LSB first, even parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] w, input bit par, output int nbits);
    logic [10:0] f;
    int n;
    n = 2 + 8 + (par ? 1 : 0);
    f = '0;
    f[n-1] = 1'b0;
    for (int k = 0; k < 8; k++) f[n-2-k] = w[k];
    if (par) f[1] = ^w;
    f[0] = 1'b1;
    nbits = n;
    return f;
  endfunction

  // Called on a negedge; leaves the bench on the negedge of the first idle cycle after the frame.
  task automatic run_frame(input logic dut, input logic [7:0] w, input logic [10:0] frame,
                           input int nbits, input int cpb, input string name, input bit keep_valid);
    int  t;
    bit  ok, ok_busy, ok_ready, ok_idle;
    logic bad;
    sel = dut;
    #0;
    t = 0;
    while (!cur_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(t < 200, {name, " ready_timeout"}, t, 0);
    if (dut) begin b_data = w; b_valid = 1'b1; end
    else     begin a_data = w; a_valid = 1'b1; end
    @(negedge clk);
    if (dut) begin b_data = 8'($urandom); if (!keep_valid) b_valid = 1'b0; end
    else     begin a_data = 8'($urandom); if (!keep_valid) a_valid = 1'b0; end
    ok_busy = 1'b1;
    ok_ready = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      ok = 1'b1;
      bad = frame[nbits-1-b];
      for (int c = 0; c < cpb; c++) begin
        if (cur_tx !== frame[nbits-1-b]) begin ok = 1'b0; bad = cur_tx; end
        if (cur_busy !== 1'b1) ok_busy = 1'b0;
        if (cur_ready !== 1'b0) ok_ready = 1'b0;
        @(negedge clk);
      end
      check(ok, $sformatf("%s tx_bit%0d", name, b), int'(bad), int'(frame[nbits-1-b]));
    end
    check(ok_busy, {name, " busy_during_frame"}, int'(ok_busy), 1);
    check(ok_ready, {name, " ready_low_during_frame"}, int'(ok_ready), 1);
    ok_idle = (cur_tx === 1'b1) && (cur_busy === 1'b0) && (cur_ready === 1'b1);
    check(ok_idle, {name, " idle_after_frame"}, int'({cur_tx, cur_busy, cur_ready}), 3'b101);
  endtask

  initial begin
    logic [10:0] f;
    int          n;
    logic [7:0]  w;
    bit          ok;

    vecs[0] = '{1'b0, 8'hA5, 11'b01010010101, 11, 4};
    vecs[1] = '{1'b0, 8'h00, 11'b00000000001, 11, 4};
    vecs[2] = '{1'b0, 8'hFF, 11'b01111111101, 11, 4};
    vecs[3] = '{1'b0, 8'h01, 11'b01000000011, 11, 4};
    vecs[4] = '{1'b0, 8'h80, 11'b00000000111, 11, 4};
    vecs[5] = '{1'b1, 8'h07, 11'b00111000001, 10, 1};
    vecs[6] = '{1'b1, 8'hFF, 11'b00111111111, 10, 1};
    vecs[7] = '{1'b1, 8'h00, 11'b00000000001, 10, 1};

    sel = 1'b0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_data = 8'hA5; b_data = 8'h07;
    a_valid = 1'b1; b_valid = 1'b0;

    // Reset held with data_valid high: nothing may start.
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) ok = 1'b0;
    end
    check(ok, "reset_hold_outputs", int'({a_tx, a_busy, a_ready}), 3'b101);
    b_rst_n = 1'b1;
    a_rst_n = 1'b1;
    run_frame(1'b0, 8'hA5, vecs[0].frame, 11, 4, "after_reset_A5", 1'b0);

    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].dut, vecs[v].data, vecs[v].frame, vecs[v].nbits, vecs[v].cpb,
                $sformatf("vec%0d", v), 1'b0);

    // Back-to-back with valid held: one idle cycle, new data ignored mid-frame.
    run_frame(1'b0, 8'h01, 11'b01000000011, 11, 4, "b2b_first", 1'b1);
    run_frame(1'b0, 8'hFF, 11'b01111111101, 11, 4, "b2b_second", 1'b0);

    // Reset in the middle of data bit 3.
    sel = 1'b0;
    @(negedge clk);
    a_data = 8'h00; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (17) @(negedge clk);
    check(a_tx === 1'b0 && a_busy === 1'b1, "midframe_before_reset", int'({a_tx, a_busy}), 2'b01);
    #2 a_rst_n = 1'b0;
    #1;
    check(a_tx === 1'b1 && a_busy === 1'b0 && a_ready === 1'b1, "midframe_async_reset",
          int'({a_tx, a_busy, a_ready}), 3'b101);
    @(negedge clk);
    a_rst_n = 1'b1;
    run_frame(1'b0, 8'h3C, 11'b00011110001, 11, 4, "after_midreset_3C", 1'b0);

    // Quiet line.
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) ok = 1'b0;
    end
    check(ok, "idle_100_cycles", int'({a_tx, a_busy, a_ready}), 3'b101);

    // Random words against the reference model.
    for (int r = 0; r < 20; r++) begin
      w = 8'($urandom);
      f = model_frame(w, 1'b1, n);
      run_frame(1'b0, w, f, n, 4, $sformatf("rand_a%0d_%02h", r, w), 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 20; r++) begin
      w = 8'($urandom);
      f = model_frame(w, 1'b0, n);
      run_frame(1'b1, w, f, n, 1, $sformatf("rand_b%0d_%02h", r, w), 1'($urandom_range(0, 1)));
    end

    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
